br_rs: RTL
==========

# br_rs

Branch reservation station and issue scheduler for the branch unit. Holds up to `ENT` dispatched branch/jump µops and captures operand values from two CDB broadcast ports. Each cycle it issues the oldest entry with both operands ready into the combinational branch unit through a valid/ready handshake. It sits between the dispatch stage and the branch execution slot, and is emptied by the pipeline flush raised on misprediction.

## Interface
- `ENT`, 4: number of entries (≥2).
- `TAG_W`, 6: ROB/physical tag width.
- `DATA_W`, 32: operand/immediate width (`RV32_DATA_WIDTH`).
- `PC_W`, 32: PC width (`RV32_PC_WIDTH`).
- `OP_W`, `ALU_OP_SEL`: compare-op select width.

Ports:
- `i_clk` in 1: clock; the only clock domain.
- `i_rst_n` in 1: synchronous reset, active-low.
- `i_flush` in 1: kill all entries.
- `i_dsp_vld` in 1: dispatch request.
- `o_dsp_rdy` out 1: entry available; equals `count != ENT`.
- `i_dsp_op` in OP_W: compare op.
- `i_dsp_is_jal`, `i_dsp_is_jalr` in 1 each: jump type.
- `i_dsp_pc` in PC_W: PC.
- `i_dsp_imm` in DATA_W: immediate.
- `i_dsp_pred` in PC_W: predicted next PC.
- `i_dsp_rob` in TAG_W: destination ROB tag.
- `i_dsp_rs1_rdy`, `i_dsp_rs2_rdy` in 1 each: operand already valid.
- `i_dsp_rs1`, `i_dsp_rs2` in DATA_W: operand value when ready, producer tag in low TAG_W bits otherwise.
- `i_cdb0_vld`, `i_cdb1_vld` in 1 each: broadcast valid.
- `i_cdb0_tag`, `i_cdb1_tag` in TAG_W: broadcast tag.
- `i_cdb0_data`, `i_cdb1_data` in DATA_W: broadcast value.
- `o_iss_vld` out 1: issue valid.
- `i_iss_rdy` in 1: branch slot accepts.
- `o_iss_op`, `o_iss_is_jal`, `o_iss_is_jalr`, `o_iss_rs1`, `o_iss_rs2`, `o_iss_pc`, `o_iss_imm`, `o_iss_pred`, `o_iss_rob` out: fields of the selected entry; widths as the matching dispatch fields.
- `o_count` out $clog2(ENT+1): occupied entries.

## Operation
- Storage is a compacting queue. Slot 0 is the oldest entry; valid slots are always `0..count-1`.
- Select: the lowest-index valid slot with `rs1_rdy & rs2_rdy`. `o_iss_vld` is 1 iff such a slot exists. `o_iss_*` are combinational muxes of registered slot state only, never of same-cycle CDB or dispatch inputs.
- Issue fires when `o_iss_vld & i_iss_rdy`. The selected slot is removed and slots above it shift down by one in the same edge.
- Dispatch fires when `i_dsp_vld & o_dsp_rdy & !i_flush`. The new entry is written at slot `count` when no issue fires, or at `count-1` when an issue fires that edge.
- A dispatch while full is ignored. It is not an error, and no state changes.
- Wakeup: for every valid slot and each CDB port, if the operand is not ready and the CDB tag equals the stored tag, the slot captures the data and sets rdy. The shifted copy of a slot keeps its wakeup.
- Dispatch bypass: if an incoming non-ready operand's tag matches a same-cycle CDB broadcast, it is written ready with the CDB data. On a tie, cdb0 has priority over cdb1; the producer guarantees equal data anyway.
- Flush: all slots are invalidated and `count` becomes 0. This takes priority over same-cycle dispatch, issue and wakeup. An issue handshake in the flush cycle is still presented to the branch slot, which must discard it.
- `count` next value = `count + dsp_fire - iss_fire`. It never exceeds ENT and never underflows.

## Timing
- Reset (`!i_rst_n` at an edge): `count`=0, all valid/rdy bits=0, `o_iss_vld`=0, `o_dsp_rdy`=1, `o_count`=0, all `o_iss_*` data=0.
- A dispatch with both operands ready, or readied via bypass, is issuable the next cycle (1-cycle dispatch→issue latency).
- An operand woken by CDB in cycle t makes its entry issuable at cycle t+1.
- Throughput is 1 issue/cycle and 1 dispatch/cycle, including the same cycle.
- When full, `o_dsp_rdy` stays 0 in the cycle an issue fires; it rises the following cycle.
- When `o_iss_vld`=1 and `i_iss_rdy`=0, the selection may change only if an older slot becomes ready. Fields always reflect the current oldest ready slot.

## Test plan
- Reset, then dispatch one ready BEQ (pc=0x100, imm=0x20, rs1=rs2=5) → cycle+1: `o_iss_vld`=1, `o_iss_pc`=0x100, `o_iss_rs1`=5. With `i_iss_rdy`=1, `o_count` goes 1→0.
- Fill 4 entries with slot1 and slot3 ready and `i_iss_rdy`=0 → `o_dsp_rdy`=0 and `o_iss_rob`=slot1 tag. A 5th dispatch is ignored and `o_count` stays 4. Raise `i_iss_rdy` → slot1 issues, then slot3 (now slot2).
- Dispatch with rs1 tag 0x12 not ready; broadcast cdb1 tag 0x12 data 0xDEAD two cycles later → issue the next cycle with `o_iss_rs1`=0xDEAD.
- Dispatch with rs2 tag 0x07 while cdb0 broadcasts tag 0x07 data 0x44 the same cycle → issuable next cycle, `o_iss_rs2`=0x44.
- With 3 entries, assert `i_flush` together with a dispatch and an issue → next cycle `o_count`=0, `o_iss_vld`=0, `o_dsp_rdy`=1.
- Full queue with issue and dispatch in the same cycle → dispatch rejected, `o_count`=3. The next cycle's dispatch is accepted.

Source files
------------

// File: rtl/br_rs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// br_rs : branch reservation station, compacting age-ordered queue with CDB
//         wakeup, dispatch bypass and oldest-ready issue.       Rev 1.0
// ---------------------------------------------------------------------------
module br_rs #(
  parameter int ENT    = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_dsp_vld,
  output logic                       o_dsp_rdy,
  input  logic [OP_W-1:0]            i_dsp_op,
  input  logic                       i_dsp_is_jal,
  input  logic                       i_dsp_is_jalr,
  input  logic [PC_W-1:0]            i_dsp_pc,
  input  logic [DATA_W-1:0]          i_dsp_imm,
  input  logic [PC_W-1:0]            i_dsp_pred,
  input  logic [TAG_W-1:0]           i_dsp_rob,
  input  logic                       i_dsp_rs1_rdy,
  input  logic                       i_dsp_rs2_rdy,
  input  logic [DATA_W-1:0]          i_dsp_rs1,
  input  logic [DATA_W-1:0]          i_dsp_rs2,
  input  logic                       i_cdb0_vld,
  input  logic [TAG_W-1:0]           i_cdb0_tag,
  input  logic [DATA_W-1:0]          i_cdb0_data,
  input  logic                       i_cdb1_vld,
  input  logic [TAG_W-1:0]           i_cdb1_tag,
  input  logic [DATA_W-1:0]          i_cdb1_data,
  output logic                       o_iss_vld,
  input  logic                       i_iss_rdy,
  output logic [OP_W-1:0]            o_iss_op,
  output logic                       o_iss_is_jal,
  output logic                       o_iss_is_jalr,
  output logic [DATA_W-1:0]          o_iss_rs1,
  output logic [DATA_W-1:0]          o_iss_rs2,
  output logic [PC_W-1:0]            o_iss_pc,
  output logic [DATA_W-1:0]          o_iss_imm,
  output logic [PC_W-1:0]            o_iss_pred,
  output logic [TAG_W-1:0]           o_iss_rob,
  output logic [$clog2(ENT+1)-1:0]   o_count
);

  localparam int CW = $clog2(ENT+1);
  localparam int IW = $clog2(ENT);

  logic [CW-1:0]     count_q, count_d;
  logic [OP_W-1:0]   op_q   [ENT];
  logic [OP_W-1:0]   op_d   [ENT];
  logic              jal_q  [ENT];
  logic              jal_d  [ENT];
  logic              jalr_q [ENT];
  logic              jalr_d [ENT];
  logic [PC_W-1:0]   pc_q   [ENT];
  logic [PC_W-1:0]   pc_d   [ENT];
  logic [DATA_W-1:0] imm_q  [ENT];
  logic [DATA_W-1:0] imm_d  [ENT];
  logic [PC_W-1:0]   pred_q [ENT];
  logic [PC_W-1:0]   pred_d [ENT];
  logic [TAG_W-1:0]  rob_q  [ENT];
  logic [TAG_W-1:0]  rob_d  [ENT];
  logic              r1_q   [ENT];
  logic              r1_d   [ENT];
  logic              r2_q   [ENT];
  logic              r2_d   [ENT];
  logic [DATA_W-1:0] v1_q   [ENT];
  logic [DATA_W-1:0] v1_d   [ENT];
  logic [DATA_W-1:0] v2_q   [ENT];
  logic [DATA_W-1:0] v2_d   [ENT];

  // Slot contents after this cycle's CDB wakeup, before compaction.
  logic              wr1 [ENT];
  logic              wr2 [ENT];
  logic [DATA_W-1:0] wv1 [ENT];
  logic [DATA_W-1:0] wv2 [ENT];

  logic              sel_vld;
  logic [IW-1:0]     sel_idx;
  logic              iss_fire, dsp_rdy, dsp_fire;
  logic [CW-1:0]     wr_pos;
  logic              byp_r1, byp_r2, sh;
  logic [DATA_W-1:0] byp_v1, byp_v2;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < ENT; i++) begin
      if (!sel_vld && (CW'(i) < count_q) && r1_q[i] && r2_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign iss_fire = sel_vld & i_iss_rdy;
  assign dsp_rdy  = (count_q != CW'(ENT));
  assign dsp_fire = i_dsp_vld & dsp_rdy & ~i_flush;
  assign wr_pos   = count_q - CW'(iss_fire);

  // cdb0 wins a tag tie on both the bypass and the stored-slot wakeup paths.
  always_comb begin
    byp_r1 = i_dsp_rs1_rdy;
    byp_v1 = i_dsp_rs1;
    byp_r2 = i_dsp_rs2_rdy;
    byp_v2 = i_dsp_rs2;
    if (!i_dsp_rs1_rdy) begin
      if (i_cdb0_vld && i_cdb0_tag == i_dsp_rs1[TAG_W-1:0]) begin
        byp_r1 = 1'b1;
        byp_v1 = i_cdb0_data;
      end else if (i_cdb1_vld && i_cdb1_tag == i_dsp_rs1[TAG_W-1:0]) begin
        byp_r1 = 1'b1;
        byp_v1 = i_cdb1_data;
      end
    end
    if (!i_dsp_rs2_rdy) begin
      if (i_cdb0_vld && i_cdb0_tag == i_dsp_rs2[TAG_W-1:0]) begin
        byp_r2 = 1'b1;
        byp_v2 = i_cdb0_data;
      end else if (i_cdb1_vld && i_cdb1_tag == i_dsp_rs2[TAG_W-1:0]) begin
        byp_r2 = 1'b1;
        byp_v2 = i_cdb1_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENT; i++) begin
      wr1[i] = r1_q[i];
      wv1[i] = v1_q[i];
      wr2[i] = r2_q[i];
      wv2[i] = v2_q[i];
      if ((CW'(i) < count_q) && !r1_q[i]) begin
        if (i_cdb0_vld && i_cdb0_tag == v1_q[i][TAG_W-1:0]) begin
          wr1[i] = 1'b1;
          wv1[i] = i_cdb0_data;
        end else if (i_cdb1_vld && i_cdb1_tag == v1_q[i][TAG_W-1:0]) begin
          wr1[i] = 1'b1;
          wv1[i] = i_cdb1_data;
        end
      end
      if ((CW'(i) < count_q) && !r2_q[i]) begin
        if (i_cdb0_vld && i_cdb0_tag == v2_q[i][TAG_W-1:0]) begin
          wr2[i] = 1'b1;
          wv2[i] = i_cdb0_data;
        end else if (i_cdb1_vld && i_cdb1_tag == v2_q[i][TAG_W-1:0]) begin
          wr2[i] = 1'b1;
          wv2[i] = i_cdb1_data;
        end
      end
    end
  end

  // Compaction: slots at or above the issued one take their upper neighbour.
  always_comb begin
    count_d = count_q + CW'(dsp_fire) - CW'(iss_fire);
    sh      = 1'b0;
    for (int i = 0; i < ENT; i++) begin
      sh        = iss_fire && (i < ENT-1) && (IW'(i) >= sel_idx);
      op_d[i]   = sh ? op_q[(i+1)%ENT]   : op_q[i];
      jal_d[i]  = sh ? jal_q[(i+1)%ENT]  : jal_q[i];
      jalr_d[i] = sh ? jalr_q[(i+1)%ENT] : jalr_q[i];
      pc_d[i]   = sh ? pc_q[(i+1)%ENT]   : pc_q[i];
      imm_d[i]  = sh ? imm_q[(i+1)%ENT]  : imm_q[i];
      pred_d[i] = sh ? pred_q[(i+1)%ENT] : pred_q[i];
      rob_d[i]  = sh ? rob_q[(i+1)%ENT]  : rob_q[i];
      r1_d[i]   = sh ? wr1[(i+1)%ENT]    : wr1[i];
      r2_d[i]   = sh ? wr2[(i+1)%ENT]    : wr2[i];
      v1_d[i]   = sh ? wv1[(i+1)%ENT]    : wv1[i];
      v2_d[i]   = sh ? wv2[(i+1)%ENT]    : wv2[i];
      if (dsp_fire && (CW'(i) == wr_pos)) begin
        op_d[i]   = i_dsp_op;
        jal_d[i]  = i_dsp_is_jal;
        jalr_d[i] = i_dsp_is_jalr;
        pc_d[i]   = i_dsp_pc;
        imm_d[i]  = i_dsp_imm;
        pred_d[i] = i_dsp_pred;
        rob_d[i]  = i_dsp_rob;
        r1_d[i]   = byp_r1;
        r2_d[i]   = byp_r2;
        v1_d[i]   = byp_v1;
        v2_d[i]   = byp_v2;
      end
      if (i_flush) begin
        r1_d[i] = 1'b0;
        r2_d[i] = 1'b0;
      end
    end
    if (i_flush) count_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
      for (int i = 0; i < ENT; i++) begin
        op_q[i]   <= '0;
        jal_q[i]  <= 1'b0;
        jalr_q[i] <= 1'b0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        pred_q[i] <= '0;
        rob_q[i]  <= '0;
        r1_q[i]   <= 1'b0;
        r2_q[i]   <= 1'b0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < ENT; i++) begin
        op_q[i]   <= op_d[i];
        jal_q[i]  <= jal_d[i];
        jalr_q[i] <= jalr_d[i];
        pc_q[i]   <= pc_d[i];
        imm_q[i]  <= imm_d[i];
        pred_q[i] <= pred_d[i];
        rob_q[i]  <= rob_d[i];
        r1_q[i]   <= r1_d[i];
        r2_q[i]   <= r2_d[i];
        v1_q[i]   <= v1_d[i];
        v2_q[i]   <= v2_d[i];
      end
    end
  end

  assign o_dsp_rdy     = dsp_rdy;
  assign o_count       = count_q;
  assign o_iss_vld     = sel_vld;
  assign o_iss_op      = sel_vld ? op_q[sel_idx]   : '0;
  assign o_iss_is_jal  = sel_vld ? jal_q[sel_idx]  : 1'b0;
  assign o_iss_is_jalr = sel_vld ? jalr_q[sel_idx] : 1'b0;
  assign o_iss_rs1     = sel_vld ? v1_q[sel_idx]   : '0;
  assign o_iss_rs2     = sel_vld ? v2_q[sel_idx]   : '0;
  assign o_iss_pc      = sel_vld ? pc_q[sel_idx]   : '0;
  assign o_iss_imm     = sel_vld ? imm_q[sel_idx]  : '0;
  assign o_iss_pred    = sel_vld ? pred_q[sel_idx] : '0;
  assign o_iss_rob     = sel_vld ? rob_q[sel_idx]  : '0;

endmodule
`default_nettype wire
